slow_tick_receiver: RTL and testbench
=====================================

Name: slow_tick_receiver

Overview:
- Receiving end of the slow toggle signal produced by our clock divider (the ~Hz-rate square wave that toggles every N+1 fast clocks).
- Synchronizes that signal into the fast `clock` domain and emits single-cycle rise, fall and toggle pulses for downstream overlay logic.
- Measures the half-period in fast-clock cycles and flags a stalled divider.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on hz_in; legal values ≥2.
- CNT_WIDTH, 27, width of the cycle counter and the half_period output.
- TIMEOUT, 5000002, cycles without an edge before the stalled flag sets; required range 2 ≤ TIMEOUT < 2^CNT_WIDTH.

Ports:
- clock  input  1  fast system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- hz_in  input  1  slow toggle signal; treated as asynchronous.
- level_sync  output  1  synchronized level of hz_in.
- rise_pulse  output  1  one-cycle pulse on each synchronized 0→1 transition.
- fall_pulse  output  1  one-cycle pulse on each synchronized 1→0 transition.
- toggle_pulse  output  1  rise_pulse OR fall_pulse, registered in the same cycle as those.
- half_period  output  CNT_WIDTH  cycles between the two most recent edges.
- half_period_valid  output  1  half_period holds a real measurement.
- stalled  output  1  no edge seen for TIMEOUT cycles.

Behaviour:
- Interface: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - All sync flops, prev-level register, cnt and half_period = 0.
  - All pulses = 0; half_period_valid = 0; stalled = 0; state = IDLE.
- Synchronizer and edge detection:
  - hz_in passes through a SYNC_STAGES-deep flop chain; level_sync is the last stage.
  - prev register holds level_sync delayed one cycle.
  - rise = level_sync & ~prev; fall = ~level_sync & prev.
  - Pulses are registered, so a pulse is high for exactly 1 cycle, SYNC_STAGES+1 rising edges after hz_in changes.
- Glitch handling: an hz_in glitch shorter than one clock may be missed or may produce a rise/fall pair. The block does not filter glitches.
- Counter cnt:
  - On an edge cycle (rise or fall detected), cnt <= 1.
  - Otherwise cnt <= cnt + 1, saturating at TIMEOUT.
- States:
  - IDLE: no edge since reset. On an edge: go to ARMED, cnt <= 1, no measurement.
  - ARMED: one edge seen.
    - On an edge: half_period <= cnt, half_period_valid <= 1, go to LOCKED.
    - If cnt reaches TIMEOUT: go to STALLED.
  - LOCKED:
    - On each edge: half_period <= cnt, valid stays 1.
    - If cnt reaches TIMEOUT: go to STALLED and clear half_period_valid.
  - STALLED: stalled = 1 and half_period holds its last value.
    - On an edge: go to ARMED, stalled <= 0, cnt <= 1.
    - A fresh measurement is needed before valid reasserts.
  - IDLE with no edge for TIMEOUT cycles: go to STALLED, so a dead divider is flagged after reset.
- Timing: half_period and half_period_valid update in the same cycle the toggle_pulse is asserted. stalled sets in the cycle after cnt first equals TIMEOUT.
- Simultaneous events: an edge in the same cycle cnt hits TIMEOUT counts as an edge. The measurement is taken, and the block does not enter STALLED.
- Reset mid-operation: asserting reset_n low clears everything immediately, including a pulse in flight. After release, the first edge only arms the block and no measurement is taken.
- Initial level: if hz_in is 1 at reset release, the first synchronized 0→1 is reported as a rise. This is intended, because prev resets to 0.

Decomposition:
- Shared package slow_tick_pkg holds:
  - the state enum (IDLE, ARMED, LOCKED, STALLED);
  - the default TIMEOUT;
  - the divider constant 2500000, so the expected half-period is 2500001.
- Sub-module sync_edge_detect is natural. It contains the SYNC_STAGES synchronizer, the prev register and the registered rise/fall pulses.
- The top level holds the counter, the state machine and the outputs.

Test Plan:
- Reset release, hz_in = 0 with no edges (TIMEOUT = 50) → stalled rises in cycle 51. No pulses; half_period_valid = 0.
- Square wave, 10 cycles high / 10 cycles low → rise/fall pulses alternate, each exactly 1 cycle wide, SYNC_STAGES+1 = 3 cycles after each hz_in change. From the second edge on, half_period = 10 and half_period_valid = 1.
- Asymmetric wave, 7 high / 13 low → half_period alternates 7 and 13. toggle_pulse fires on every edge.
- Wave stops after lock (TIMEOUT = 50) → stalled = 1 and valid = 0 when cnt reaches 50. half_period retains 10. On the next edge the block returns to ARMED; on the one after, valid = 1.
- reset_n pulsed low for 3 cycles during LOCKED → all outputs read 0 during reset. After release the next edge gives no valid; the second edge gives a correct measurement.
- Edge arrives in the exact cycle cnt = TIMEOUT → no stalled assertion, and half_period = TIMEOUT.

Source files
------------

// File: rtl/slow_tick_pkg.sv
// Shared types and constants for the slow divider-tick receiver.
// The divider toggles every DIVIDER_N+1 fast clocks, so a healthy half-period reads EXPECTED_HALF_PERIOD.
package slow_tick_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } state_t;

    localparam int DIVIDER_N            = 2500000;
    localparam int EXPECTED_HALF_PERIOD = DIVIDER_N + 1;
    localparam int DEFAULT_TIMEOUT      = 5000002;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous slow level, with registered rise/fall/toggle pulses.
// rise_det/fall_det are the unregistered detections, aligned with the cycle the pulses get loaded.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic hz_in,
    output logic level_sync,
    output logic rise_det,
    output logic fall_det,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic toggle_pulse
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;

    assign level_sync = sync_p0[SYNC_STAGES-1];
    assign rise_det   = level_sync & ~prev_p1;
    assign fall_det   = ~level_sync & prev_p1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0      <= '0;
            prev_p1      <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            toggle_pulse <= 1'b0;
        end else begin
            sync_p0      <= {sync_p0[SYNC_STAGES-2:0], hz_in};
            // stage boundary: previous synchronized level for edge detection
            prev_p1      <= level_sync;
            rise_pulse   <= rise_det;
            fall_pulse   <= fall_det;
            toggle_pulse <= rise_det | fall_det;
        end
    end

endmodule

// File: rtl/slow_tick_receiver.sv
// Receives the divider's slow toggle: synchronizes it, pulses on edges, measures the half-period
// and flags a divider that has stopped toggling.
module slow_tick_receiver
    import slow_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 27,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 hz_in,
    output logic                 level_sync,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 toggle_pulse,
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 half_period_valid,
    output logic                 stalled
);

    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 rise_det;
    logic                 fall_det;
    logic                 edge_det;
    logic                 at_limit;
    logic [CNT_WIDTH-1:0] cnt;
    state_t               state;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock        (clock),
        .reset_n      (reset_n),
        .hz_in        (hz_in),
        .level_sync   (level_sync),
        .rise_det     (rise_det),
        .fall_det     (fall_det),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .toggle_pulse (toggle_pulse)
    );

    assign edge_det = rise_det | fall_det;
    assign at_limit = (cnt == CNT_LIMIT);

    // An edge always wins over the timeout, even when both land in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            half_period       <= '0;
            half_period_valid <= 1'b0;
            stalled           <= 1'b0;
        end else begin
            if (edge_det) begin
                cnt <= CNT_ONE;
            end else if (!at_limit) begin
                cnt <= cnt + CNT_ONE;
            end

            unique case (state)
                IDLE: begin
                    if (edge_det) begin
                        state <= ARMED;
                    end else if (at_limit) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                    end
                end
                ARMED: begin
                    if (edge_det) begin
                        state             <= LOCKED;
                        half_period       <= cnt;
                        half_period_valid <= 1'b1;
                    end else if (at_limit) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        half_period <= cnt;
                    end else if (at_limit) begin
                        state             <= STALLED;
                        stalled           <= 1'b1;
                        half_period_valid <= 1'b0;
                    end
                end
                STALLED: begin
                    if (edge_det) begin
                        state   <= ARMED;
                        stalled <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_tick_receiver.sv
// Directed bench for slow_tick_receiver with a short TIMEOUT so stall paths are reachable.
module tb_slow_tick_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_WIDTH   = 27;
    localparam int TIMEOUT     = 50;

    logic                 clock;
    logic                 reset_n;
    logic                 hz_in;
    logic                 level_sync;
    logic                 rise_pulse;
    logic                 fall_pulse;
    logic                 toggle_pulse;
    logic [CNT_WIDTH-1:0] half_period;
    logic                 half_period_valid;
    logic                 stalled;

    int errors = 0;
    int checks = 0;

    slow_tick_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_WIDTH   (CNT_WIDTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .hz_in             (hz_in),
        .level_sync        (level_sync),
        .rise_pulse        (rise_pulse),
        .fall_pulse        (fall_pulse),
        .toggle_pulse      (toggle_pulse),
        .half_period       (half_period),
        .half_period_valid (half_period_valid),
        .stalled           (stalled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},  32'(level_sync),        32'd0);
        chk({tag, "_rise"},   32'(rise_pulse),        32'd0);
        chk({tag, "_fall"},   32'(fall_pulse),        32'd0);
        chk({tag, "_toggle"}, 32'(toggle_pulse),      32'd0);
        chk({tag, "_hp"},     32'(half_period),       32'd0);
        chk({tag, "_valid"},  32'(half_period_valid), 32'd0);
        chk({tag, "_stall"},  32'(stalled),           32'd0);
    endtask

    // Drive hz_in to lvl for n cycles; the edge pulse must appear on the 3rd cycle only.
    task automatic do_half(input logic lvl, input int n, input logic exp_valid,
                           input int exp_hp, input string tag);
        hz_in = lvl;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == SYNC_STAGES + 1) begin
                chk({tag, "_rise"},   32'(rise_pulse),        32'(lvl));
                chk({tag, "_fall"},   32'(fall_pulse),        32'(!lvl));
                chk({tag, "_toggle"}, 32'(toggle_pulse),      32'd1);
                chk({tag, "_hp"},     32'(half_period),       32'(exp_hp));
                chk({tag, "_valid"},  32'(half_period_valid), 32'(exp_valid));
            end else begin
                chk({tag, "_quiet"},  32'(toggle_pulse),      32'd0);
            end
            if (i >= SYNC_STAGES) chk({tag, "_level"}, 32'(level_sync), 32'(lvl));
            if (i >= SYNC_STAGES + 1) chk({tag, "_nostall"}, 32'(stalled), 32'd0);
        end
    endtask

    initial begin
        logic any_pulse;
        reset_n = 1'b0;
        hz_in   = 1'b0;
        #1;
        chk_all_zero("reset_async");
        tick();
        tick();
        chk_all_zero("reset_held");

        // Dead divider after reset: stalled appears after the 51st edge.
        reset_n   = 1'b1;
        any_pulse = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            any_pulse |= toggle_pulse;
        end
        chk("idle_pre_stall", 32'(stalled), 32'd0);
        tick();
        any_pulse |= toggle_pulse;
        chk("idle_stall", 32'(stalled), 32'd1);
        chk("idle_nopulse", 32'(any_pulse), 32'd0);
        chk("idle_valid", 32'(half_period_valid), 32'd0);
        chk("idle_hp", 32'(half_period), 32'd0);

        // Asymmetric then symmetric waves; each edge reports the previous segment length.
        do_half(1'b1, 7,  1'b0, 0,  "asym_arm");
        do_half(1'b0, 13, 1'b1, 7,  "asym_f1");
        do_half(1'b1, 7,  1'b1, 13, "asym_r1");
        do_half(1'b0, 13, 1'b1, 7,  "asym_f2");
        do_half(1'b1, 10, 1'b1, 13, "sq_r1");
        do_half(1'b0, 10, 1'b1, 10, "sq_f1");
        do_half(1'b1, 10, 1'b1, 10, "sq_r2");
        do_half(1'b0, 10, 1'b1, 10, "sq_f2");

        // Wave stops while locked: cnt hits TIMEOUT after 52 cycles, stall shows after 53.
        repeat (42) tick();
        chk("lock_pre_stall", 32'(stalled), 32'd0);
        chk("lock_pre_valid", 32'(half_period_valid), 32'd1);
        tick();
        chk("lock_stall", 32'(stalled), 32'd1);
        chk("lock_stall_valid", 32'(half_period_valid), 32'd0);
        chk("lock_stall_hp", 32'(half_period), 32'd10);

        // Recovery, then an edge landing exactly on cnt == TIMEOUT.
        do_half(1'b1, 10, 1'b0, 10, "recover_arm");
        do_half(1'b0, 50, 1'b1, 10, "recover_meas");
        do_half(1'b1, 10, 1'b1, 50, "edge_at_timeout");

        // Reset pulse while locked with hz_in high.
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset_now");
        tick();
        tick();
        tick();
        chk_all_zero("midreset_held");
        reset_n = 1'b1;
        do_half(1'b1, 10, 1'b0, 0,  "post_reset_arm");
        do_half(1'b0, 10, 1'b1, 10, "post_reset_meas");
        do_half(1'b1, 10, 1'b1, 10, "post_reset_meas2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
